// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Defines operation codes, FSM states and the MIPS funct encodings used by the decoder.
package hilo_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  // Magnitude of a 32-bit operand; 0x8000_0000 maps to itself, which the unsigned divider handles.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_iter_divider.sv
// Unsigned 32-bit restoring divider: one quotient bit per cycle, 32 cycles after start.
// Sign handling and divide-by-zero policy live in the controller.
module iter_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [5:0]  cnt;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff;

  // When trial >= divisor the true difference is below 2^32, so 32 bits suffice.
  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial[31:0] - dvs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt   <= 6'd32;
      valid <= 1'b0;
    end else if (cnt != 6'd0) begin
      rem_q <= ge ? diff : trial[31:0];
      quo_q <= {quo_q[30:0], ge};
      cnt   <= cnt - 6'd1;
      if (cnt == 6'd1) valid <= 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle MUL/DIV sequencer; stalls the pipeline while busy.
// Optional HILO_MADD_EN adds MADD/MSUB accumulate into {HI,LO}.
//
// state   | meaning
// IDLE    | accepts start, MTHI/MTLO write immediately, serves MFHI/MFLO
// MUL     | product pending, cnt counts down to the write cycle
// DIV     | 32 divider iterations, cnt counts down to 0
// FIX     | apply signs / div-by-zero policy, write HI/LO, pulse done
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_ITERS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        mf_req,
  input  logic        mf_sel_hi,
  output logic [31:0] hilo_rd,
  output logic        stall,
  output logic        busy,
  output logic        done
);

  md_state_t   state, state_nx;
  muldiv_op_t  op_e;
  logic [5:0]  cnt;
  logic [31:0] hi, lo, a_q, b_q;
  logic        sgn_q;
  logic        op_ok, accept, is_mul_op, is_div_op, op_signed;
  logic        wr_mul, wr_div;
  logic [63:0] mul_a, mul_b, prod, mul_res;
  logic [31:0] quo, rem, q_fix, r_fix;
  logic        div_valid, div0;

  assign op_e = muldiv_op_t'(op);

`ifdef HILO_MADD_EN
  logic madd_q, msub_q;
  assign op_ok = 1'b1;
`else
  assign op_ok = (op_e != MD_MADD) && (op_e != MD_MSUB);
`endif

  assign is_mul_op = (op_e == MD_MULT) || (op_e == MD_MULTU) ||
                     (op_e == MD_MADD) || (op_e == MD_MSUB);
  assign is_div_op = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign op_signed = (op_e == MD_MULT) || (op_e == MD_DIV) ||
                     (op_e == MD_MADD) || (op_e == MD_MSUB);
  assign accept    = (state == ST_IDLE) && start && !flush && op_ok;
  assign busy      = (state != ST_IDLE);
  assign stall     = busy && (start || mf_req);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    wr_mul   = 1'b0;
    wr_div   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op)      state_nx = ST_MUL;
        else if (accept && is_div_op) state_nx = ST_DIV;
      end
      ST_MUL: begin
        if (flush) state_nx = ST_IDLE;
        else if (cnt == 6'd0) begin
          state_nx = ST_IDLE;
          done     = !reset;
          wr_mul   = !reset;
        end
      end
      ST_DIV: begin
        if (flush)            state_nx = ST_IDLE;
        else if (cnt == 6'd0) state_nx = ST_FIX;
      end
      ST_FIX: begin
        state_nx = ST_IDLE;
        if (!flush && !reset && div_valid) begin
          done   = 1'b1;
          wr_div = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Down-counter: loaded on accept, terminal count 0 marks the last MUL/DIV cycle.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (state == ST_IDLE) begin
      if (accept && is_mul_op)      cnt <= 6'(MUL_LATENCY - 1);
      else if (accept && is_div_op) cnt <= 6'(DIV_ITERS - 1);
      else                          cnt <= '0;
    end else if (cnt != 6'd0) cnt <= cnt - 6'd1;
  end

  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

`ifdef HILO_MADD_EN
  assign mul_res = madd_q ? ({hi, lo} + prod) :
                   msub_q ? ({hi, lo} - prod) : prod;
`else
  assign mul_res = prod;
`endif

  iter_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && is_div_op),
    .dividend (mag32(src_a, op_signed)),
    .divisor  (mag32(src_b, op_signed)),
    .quotient (quo),
    .remainder(rem),
    .valid    (div_valid)
  );

  assign div0  = (b_q == 32'd0);
  assign q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (~quo + 32'd1) : quo;
  assign r_fix = (sgn_q && a_q[31]) ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
`ifdef HILO_MADD_EN
      madd_q <= 1'b0;
      msub_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q   <= src_a;
        b_q   <= src_b;
        sgn_q <= op_signed;
`ifdef HILO_MADD_EN
        madd_q <= (op_e == MD_MADD);
        msub_q <= (op_e == MD_MSUB);
`endif
        if (op_e == MD_MTHI) hi <= src_a;
        if (op_e == MD_MTLO) lo <= src_a;
      end
      if (wr_mul) {hi, lo} <= mul_res;
      // Divide by zero returns all-ones quotient and the original dividend.
      if (wr_div) begin
        lo <= div0 ? 32'hFFFF_FFFF : q_fix;
        hi <= div0 ? a_q : r_fix;
      end
    end
  end

  always_comb begin
    hilo_rd = '0;
    if (mf_req && !busy) begin
      if (accept && mf_sel_hi && (op_e == MD_MTHI))       hilo_rd = src_a;
      else if (accept && !mf_sel_hi && (op_e == MD_MTLO)) hilo_rd = src_a;
      else                                                hilo_rd = mf_sel_hi ? hi : lo;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl: vector table plus multi-cycle sequences.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush, mf_req, mf_sel_hi;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hilo_rd;
  logic        stall, busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.MUL_LATENCY(4), .DIV_ITERS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .mf_req   (mf_req),
    .mf_sel_hi(mf_sel_hi),
    .hilo_rd  (hilo_rd),
    .stall    (stall),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    mf_req = 1'b1;
    mf_sel_hi = 1'b1;
    #1;
    chk({tag, " hi"}, hilo_rd, eh);
    mf_sel_hi = 1'b0;
    #1;
    chk({tag, " lo"}, hilo_rd, el);
    mf_req = 1'b0;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int cyc;
    int dcyc;
    start = 1'b1;
    op    = v.op;
    src_a = v.a;
    src_b = v.b;
    #1;
    step();
    start = 1'b0;
    #1;
    cyc  = 1;
    dcyc = 0;
    while (busy && cyc < 60) begin
      if (done) dcyc = cyc;
      step();
      cyc++;
    end
    chk($sformatf("v%0d done_cycle", idx), dcyc, v.cyc);
    chk($sformatf("v%0d busy_cycles", idx), cyc - 1, v.cyc);
    read_hilo($sformatf("v%0d", idx), v.hi, v.lo);
  endtask

  initial begin
    int cyc, dcyc, nstall;
    logic dflag;

    vecs.push_back('{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 4});
    vecs.push_back('{MD_MULTU, 32'hFFFF_FFFD, 32'd7,        32'h0000_0006, 32'hFFFF_FFEB, 4});
    vecs.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vecs.push_back('{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33});
    vecs.push_back('{MD_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 33});
    vecs.push_back('{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33});
    vecs.push_back('{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33});
    vecs.push_back('{MD_DIVU,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 33});
    vecs.push_back('{MD_MTLO,  32'd10,        32'd0,        32'hFFFF_FFF9, 32'd10,        0});
    vecs.push_back('{MD_MTHI,  32'd0,         32'd0,        32'd0,         32'd10,        0});
`ifdef HILO_MADD_EN
    vecs.push_back('{MD_MADD,  32'd3,         32'd4,        32'd0,         32'd22,        4});
    vecs.push_back('{MD_MSUB,  32'd5,         32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 4});
`else
    vecs.push_back('{MD_MADD,  32'd3,         32'd4,        32'd0,         32'd10,        0});
`endif

    reset = 1'b1; start = 1'b0; flush = 1'b0; mf_req = 1'b0; mf_sel_hi = 1'b0;
    op = 3'd0; src_a = '0; src_b = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset stall", stall, 0);
    chk("reset rd idle", hilo_rd, 0);
    read_hilo("reset", 32'd0, 32'd0);

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // MFLO issued during a MULT is stalled until the product lands.
    start = 1'b1; op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
    step();
    start = 1'b0;
    step();
    mf_req = 1'b1; mf_sel_hi = 1'b0;
    #1;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("mf stall c%0d", c), stall, 1);
      chk($sformatf("mf rd busy c%0d", c), hilo_rd, 0);
      if (c == 4) chk("mul done c4", done, 1);
      step();
    end
    chk("mf stall c5", stall, 0);
    chk("mf rd c5", hilo_rd, 32'd6);
    mf_req = 1'b0;

    // MTHI bypass to a same-cycle MFHI.
    start = 1'b1; op = MD_MTHI; src_a = 32'hDEAD_BEEF; mf_req = 1'b1; mf_sel_hi = 1'b1;
    #1;
    chk("mthi bypass rd", hilo_rd, 32'hDEAD_BEEF);
    chk("mthi bypass stall", stall, 0);
    chk("mthi busy", busy, 0);
    step();
    start = 1'b0; src_a = '0;
    #1;
    chk("mfhi after mthi", hilo_rd, 32'hDEAD_BEEF);
    mf_req = 1'b0;

    // Start arriving during a DIVU is held until the first IDLE cycle.
    start = 1'b1; op = MD_DIVU; src_a = 32'd9; src_b = 32'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1; op = MD_MTLO; src_a = 32'h55;
    #1;
    cyc = 5; dcyc = 0; nstall = 0;
    while (busy && cyc < 60) begin
      if (stall) nstall++;
      if (done) dcyc = cyc;
      step();
      cyc++;
    end
    chk("held start idle cycle", cyc, 34);
    chk("held start stall cycles", nstall, 29);
    chk("held div done cycle", dcyc, 33);
    chk("held start no stall idle", stall, 0);
    step();
    start = 1'b0;
    #1;
    read_hilo("held mtlo", 32'd1, 32'h55);

    // Flush at cycle 10 of a DIVU leaves HI/LO alone and never pulses done.
    start = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    step();
    start = 1'b0;
    #1;
    dflag = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (done) dflag = 1'b1;
      step();
    end
    flush = 1'b1;
    #1;
    if (done) dflag = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush div idle c11", busy, 0);
    for (int c = 0; c < 30; c++) begin
      if (done) dflag = 1'b1;
      step();
    end
    chk("flush div no done", dflag, 0);
    read_hilo("flush div", 32'd1, 32'h55);

    // Flush in the final MUL cycle suppresses the write.
    start = 1'b1; op = MD_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1;
    #1;
    chk("flush last busy", busy, 1);
    chk("flush last done", done, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush last idle", busy, 0);
    read_hilo("flush last", 32'd1, 32'h55);

    // flush together with start in IDLE ignores the start.
    start = 1'b1; flush = 1'b1; op = MD_MTLO; src_a = 32'h1234;
    step();
    op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush start busy", busy, 0);
    read_hilo("flush start", 32'd1, 32'h55);

    // Reset during cycle 2 of a MULT.
    start = 1'b1; op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset done", done, 0);
    read_hilo("mid reset", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
